// File: rtl/bp_be_pkg.sv
// Shared types for the back-end next-PC checker: config selector, branch packet,
// redirect payload and checker state encoding.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int vaddr_width_gp               = 39;
  localparam int branch_metadata_fwd_width_gp = 36;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return vaddr_width_gp;
      default:          return vaddr_width_gp;
    endcase
  endfunction

  function automatic int bp_metadata_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return branch_metadata_fwd_width_gp;
      default:          return branch_metadata_fwd_width_gp;
    endcase
  endfunction

  typedef struct packed {
    logic                      v;
    logic                      branch;
    logic                      btaken;
    logic [vaddr_width_gp-1:0] npc;
  } bp_be_branch_pkt_s;

  typedef struct packed {
    logic [vaddr_width_gp-1:0]               pc;
    logic                                    taken;
    logic [branch_metadata_fwd_width_gp-1:0] metadata;
  } bp_be_redirect_s;

  typedef enum logic [1:0] {
    e_run,
    e_wait_fe,
    e_resync
  } bp_be_npc_check_state_e;

endpackage

// File: rtl/bp_be_npc_check.sv
// Tracks the architectural next PC, poisons wrong-path issue and raises a single
// front-end redirect per mispredict, then drops instructions until the stream resyncs.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// e_run     | stream on the expected path; a mismatch raises a redirect
// e_wait_fe | redirect pending; every issuing instruction is wrong-path
// e_resync  | drop instructions until one lands on the expected PC
module bp_be_npc_check
  import bp_be_pkg::*;
  #(parameter bp_params_e                  bp_params_p  = e_bp_default_cfg
    , parameter logic [vaddr_width_gp-1:0] reset_pc_p   = 'h8000_0000
    , parameter int                        cnt_width_p  = 32
    , localparam int vaddr_width_p                = bp_vaddr_width(bp_params_p)
    , localparam int branch_metadata_fwd_width_p  = bp_metadata_width(bp_params_p)
    )
  (input  logic                                   clk_i
  , input  logic                                   reset_i
  , input  bp_be_branch_pkt_s                      br_pkt_i
  , input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_i
  , input  logic                                   issue_v_i
  , input  logic [vaddr_width_p-1:0]               issue_pc_i
  , input  logic                                   npc_w_v_i
  , input  logic [vaddr_width_p-1:0]               npc_w_i
  , output logic                                   poison_o
  , output logic [vaddr_width_p-1:0]               npc_o
  , output logic                                   redirect_v_o
  , input  logic                                   redirect_ready_i
  , output logic [vaddr_width_p-1:0]               redirect_pc_o
  , output logic                                   redirect_taken_o
  , output logic [branch_metadata_fwd_width_p-1:0] redirect_metadata_o
  , output logic [cnt_width_p-1:0]                 mispredict_cnt_o
  );

  bp_be_npc_check_state_e   state_r;
  logic [vaddr_width_p-1:0] npc_r;
  logic [vaddr_width_p-1:0] cmp_pc;
  logic                     pc_match;
  logic                     mispredict;
  logic                     redirect_v_r;
  bp_be_redirect_s          redirect_r;
  logic [cnt_width_p-1:0]   cnt_r;
  logic                     unused_branch;

  // The branch packet belongs to the older instruction, so its npc bypasses npc_r.
  assign cmp_pc        = br_pkt_i.v ? br_pkt_i.npc : npc_r;
  assign pc_match      = (issue_pc_i == cmp_pc);
  assign mispredict    = (state_r == e_run) & issue_v_i & ~pc_match;
  assign unused_branch = br_pkt_i.branch;

  always_comb begin
    poison_o = 1'b0;
    case (state_r)
      e_run:     poison_o = issue_v_i & ~pc_match;
      e_wait_fe: poison_o = issue_v_i;
      e_resync:  poison_o = issue_v_i & ~pc_match;
      default:   poison_o = issue_v_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_resync;
      npc_r        <= reset_pc_p;
      redirect_v_r <= 1'b0;
      redirect_r   <= '0;
      cnt_r        <= '0;
    end else if (npc_w_v_i) begin
      // Trap/xRET: drop any pending redirect and realign to the new PC.
      state_r      <= e_resync;
      npc_r        <= npc_w_i;
      redirect_v_r <= 1'b0;
    end else begin
      if (br_pkt_i.v)
        npc_r <= br_pkt_i.npc;
      case (state_r)
        e_run: begin
          if (mispredict) begin
            state_r             <= e_wait_fe;
            redirect_v_r        <= 1'b1;
            redirect_r.pc       <= {cmp_pc[vaddr_width_p-1:1], 1'b0};
            redirect_r.taken    <= br_pkt_i.btaken;
            redirect_r.metadata <= br_metadata_i;
            if (cnt_r != '1)
              cnt_r <= cnt_r + 1'b1;
          end
        end
        e_wait_fe: begin
          if (redirect_v_r & redirect_ready_i) begin
            state_r      <= e_resync;
            redirect_v_r <= 1'b0;
          end
        end
        e_resync: begin
          if (issue_v_i & pc_match)
            state_r <= e_run;
        end
        default: state_r <= e_resync;
      endcase
    end
  end

  assign npc_o               = npc_r;
  assign redirect_v_o        = redirect_v_r;
  assign redirect_pc_o       = redirect_r.pc;
  assign redirect_taken_o    = redirect_r.taken;
  assign redirect_metadata_o = redirect_r.metadata;
  assign mispredict_cnt_o    = cnt_r;

endmodule

// File: tb/tb_bp_be_npc_check.sv
// Directed plus randomized bench for bp_be_npc_check against a behavioural
// next-PC model; a narrow counter makes saturation reachable.
module tb_bp_be_npc_check;
  import bp_be_pkg::*;

  localparam int VW  = vaddr_width_gp;
  localparam int MW  = branch_metadata_fwd_width_gp;
  localparam int CW  = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [VW-1:0] RESET_PC = 'h8000_0000;

  logic              clk = 1'b0;
  logic              reset_i;
  bp_be_branch_pkt_s br_pkt;
  logic [MW-1:0]     br_metadata;
  logic              issue_v;
  logic [VW-1:0]     issue_pc;
  logic              npc_w_v;
  logic [VW-1:0]     npc_w;
  logic              poison;
  logic [VW-1:0]     npc;
  logic              redirect_v;
  logic              redirect_ready;
  logic [VW-1:0]     redirect_pc;
  logic              redirect_taken;
  logic [MW-1:0]     redirect_metadata;
  logic [CW-1:0]     mispredict_cnt;

  always #5 clk = ~clk;

  bp_be_npc_check #(.reset_pc_p(RESET_PC), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_i(reset_i), .br_pkt_i(br_pkt), .br_metadata_i(br_metadata),
    .issue_v_i(issue_v), .issue_pc_i(issue_pc), .npc_w_v_i(npc_w_v), .npc_w_i(npc_w),
    .poison_o(poison), .npc_o(npc), .redirect_v_o(redirect_v),
    .redirect_ready_i(redirect_ready), .redirect_pc_o(redirect_pc),
    .redirect_taken_o(redirect_taken), .redirect_metadata_o(redirect_metadata),
    .mispredict_cnt_o(mispredict_cnt));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: expected PC, whether a redirect awaits the front end, whether we are
  // discarding until realignment, and the last redirect that was raised.
  logic [VW-1:0] m_npc;
  bit            m_awaiting_fe;
  bit            m_discarding;
  bit            m_rv;
  logic [VW-1:0] m_rpc;
  bit            m_rtaken;
  logic [MW-1:0] m_rmeta;
  int            m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_npc = RESET_PC; m_awaiting_fe = 0; m_discarding = 1;
    m_rv = 0; m_rpc = '0; m_rtaken = 0; m_rmeta = '0; m_cnt = 0;
  endtask

  function automatic logic [VW-1:0] rand_pc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {r[VW-1:2], 2'b00};
  endfunction

  // One cycle: drive at negedge, check everything the model predicts, then
  // advance the model to what the DUT should hold after the next posedge.
  task automatic step(input bit chk, input bit rst, input bit iv, input logic [VW-1:0] ipc,
                      input bit bv, input bit btk, input logic [VW-1:0] bnpc,
                      input logic [MW-1:0] meta, input bit wv, input logic [VW-1:0] w,
                      input bit rdy);
    logic [VW-1:0] target;
    bit            exp_poison;
    @(negedge clk);
    reset_i = rst; issue_v = iv; issue_pc = ipc;
    br_pkt.v = bv; br_pkt.branch = bv; br_pkt.btaken = btk; br_pkt.npc = bnpc;
    br_metadata = meta; npc_w_v = wv; npc_w = w; redirect_ready = rdy;
    #1;
    target = bv ? bnpc : m_npc;
    exp_poison = m_awaiting_fe ? iv : (iv && ipc != target);
    if (chk) begin
      check("poison", 64'(poison), 64'(exp_poison));
      check("npc", 64'(npc), 64'(m_npc));
      check("redirect_v", 64'(redirect_v), 64'(m_rv));
      check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
      check("redirect_taken", 64'(redirect_taken), 64'(m_rtaken));
      check("redirect_meta", 64'(redirect_metadata), 64'(m_rmeta));
      check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_cnt));
    end
    if (rst) model_reset();
    else if (wv) begin
      m_npc = w; m_awaiting_fe = 0; m_discarding = 1; m_rv = 0;
    end else begin
      if (bv) m_npc = bnpc;
      if (m_awaiting_fe) begin
        if (rdy) begin m_awaiting_fe = 0; m_discarding = 1; m_rv = 0; end
      end else if (m_discarding) begin
        if (iv && ipc == target) m_discarding = 0;
      end else if (iv && ipc != target) begin
        m_awaiting_fe = 1; m_rv = 1;
        m_rpc = {target[VW-1:1], 1'b0}; m_rtaken = btk; m_rmeta = meta;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  task automatic issue(input logic [VW-1:0] pc, input bit rdy);
    step(1, 0, 1, pc, 0, 0, '0, '0, 0, '0, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1, 0, 0, '0, 0, 0, '0, '0, 0, '0, rdy);
  endtask

  initial begin
    logic [VW-1:0] bnpc, ipc, tgt;
    logic [63:0]   r;
    bit            bv, iv, wv, rst;
    int            sel;
    model_reset();
    reset_i = 1; issue_v = 0; issue_pc = '0; br_pkt = '0; br_metadata = '0;
    npc_w_v = 0; npc_w = '0; redirect_ready = 0;
    step(0, 1, 0, '0, 0, 0, '0, '0, 0, '0, 0);
    step(0, 1, 0, '0, 0, 0, '0, '0, 0, '0, 0);

    // Reset state and first aligned issue
    issue(VW'('h8000_0000), 0);
    check("reset_cnt_const", 64'(mispredict_cnt), 64'd0);
    // Bypassed branch packet with same-cycle issue
    step(1, 0, 1, VW'('h8000_0100), 1, 1, VW'('h8000_0100), MW'('h5a5), 0, '0, 0);
    // Mispredict against the expected PC
    step(1, 0, 1, VW'('h8000_0004), 0, 1, '0, MW'('h123), 0, '0, 0);
    check("redirect_v_rise", 64'(redirect_v), 64'd0);
    // Front end stalls; wrong-path issue is all poisoned
    issue(VW'('h8000_0008), 0);
    check("redirect_pc_const", 64'(redirect_pc), 64'h8000_0100);
    idle(0);
    issue(VW'('h8000_000c), 0);
    idle(0);
    issue(VW'('h8000_0100), 0);
    idle(1);
    idle(0);
    // Resync: off-path dropped silently, on-path passes
    issue(VW'('h8000_0008), 0);
    issue(VW'('h8000_0100), 0);
    issue(VW'('h8000_0100), 0);
    // Trap overwrite cancels a pending redirect
    issue(VW'('h8000_0200), 0);
    step(1, 0, 0, '0, 0, 0, '0, '0, 1, VW'('h8000_2000), 0);
    idle(1);
    issue(VW'('h8000_2000), 0);
    idle(0);
    // Reset in the middle of a handshake
    issue(VW'('h8000_3000), 0);
    idle(0);
    step(1, 1, 0, '0, 0, 0, '0, '0, 0, '0, 0);
    idle(0);
    // Saturation of the narrow counter
    issue(RESET_PC, 0);
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      step(1, 0, 1, RESET_PC + VW'(4), 0, i[0], '0, MW'(i), 0, '0, 0);
      idle(1);
      issue(RESET_PC, 0);
    end
    check("cnt_saturated_const", 64'(mispredict_cnt), 64'(CNT_MAX));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bv = ($urandom_range(0, 3) == 0);
      bnpc = ($urandom_range(0, 1) == 0) ? m_npc + VW'(4) : rand_pc();
      tgt = bv ? bnpc : m_npc;
      sel = $urandom_range(0, 3);
      ipc = (sel < 2) ? tgt : (sel == 2) ? tgt + VW'(4) : rand_pc();
      iv  = ($urandom_range(0, 9) < 7);
      wv  = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 199) == 0);
      r = {$urandom(), $urandom()};
      step(1, rst, iv, ipc, bv, $urandom_range(0, 1) == 1, bnpc, r[MW-1:0],
           wv, rand_pc(), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_npc_check.md
# bp_be_npc_check

Next-PC checker that sits directly downstream of the control pipe in the back-end calculator. It consumes the resolved branch packet (valid, branch, taken, npc) and tracks the architecturally expected next PC. Each instruction entering execute is compared against that PC. On a mismatch the block poisons the wrong-path instruction, sends one redirect to the front end over a valid/ready handshake, and drops wrong-path instructions until the stream resynchronises.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p and branch_metadata_fwd_width_p.
- reset_pc_p, 'h8000_0000, value loaded into the expected-PC register on reset.
- cnt_width_p, 32, width of the mispredict counter.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- br_pkt_i  in  bp_be_branch_pkt_s  resolved packet from the control pipe (v, branch, btaken, npc).
- br_metadata_i  in  branch_metadata_fwd_width_p  metadata of the resolving instruction.
- issue_v_i  in  1  an instruction is entering execute this cycle.
- issue_pc_i  in  vaddr_width_p  PC of that instruction.
- npc_w_v_i  in  1  trap/xRET overwrite of the expected PC.
- npc_w_i  in  vaddr_width_p  new expected PC.
- poison_o  out  1  kill the current issue instruction (combinational).
- npc_o  out  vaddr_width_p  current expected PC (registered).
- redirect_v_o  out  1  redirect request to the front end.
- redirect_ready_i  in  1  front end accepts the redirect.
- redirect_pc_o  out  vaddr_width_p  redirect target.
- redirect_taken_o  out  1  resolving branch was taken.
- redirect_metadata_o  out  branch_metadata_fwd_width_p  forwarded metadata.
- mispredict_cnt_o  out  cnt_width_p  saturating mispredict count.

## Operation
- npc_r is the expected PC.
  - br_pkt_i.v=1 → npc_r ← br_pkt_i.npc.
  - npc_w_v_i=1 overrides br_pkt_i and loads npc_w_i.
- Compare target cmp_pc = br_pkt_i.v ? br_pkt_i.npc : npc_r. The bypass exists because the packet belongs to the older instruction.
- States:
  - e_run:
    - issue_v_i & issue_pc_i≠cmp_pc → poison_o=1.
    - Latch redirect = {cmp_pc, br_pkt_i.btaken, br_metadata_i}.
    - Increment the counter, saturating at all-ones.
    - Go to e_wait_fe.
    - Matching instructions pass unpoisoned.
  - e_wait_fe:
    - redirect_v_o=1; the payload is held stable.
    - redirect_v_o & redirect_ready_i → e_resync.
    - Every issue_v_i is poisoned. No new redirect is generated.
  - e_resync:
    - An issue_v_i with issue_pc_i≠cmp_pc is poisoned silently.
    - The first issue_v_i with issue_pc_i=cmp_pc is not poisoned → e_run.
- npc_w_v_i in any state:
  - Cancels any pending redirect (redirect_v_o drops the next cycle).
  - Next state is e_resync.
  - The counter does not increment.
- Priority: reset_i > npc_w_v_i > mispredict detect > br_pkt_i update.
- redirect_pc_o[0] is forced to 0.
- Arithmetic:
  - All PCs are vaddr_width_p wide; comparisons are unsigned equality.
  - The counter increments only on e_run mismatches.

## Timing
- Reset values:
  - npc_r=reset_pc_p; state=e_resync.
  - redirect_v_o=0; redirect_pc_o=0; redirect_taken_o=0; redirect_metadata_o=0.
  - mispredict_cnt_o=0.
  - poison_o=issue_v_i & issue_pc_i≠reset_pc_p.
- poison_o is combinational from issue_v_i, issue_pc_i, br_pkt_i and state, with zero latency.
- redirect_v_o rises the cycle after detection. Detection-to-request latency is 1.
- Handshake:
  - redirect_v_o does not depend combinationally on redirect_ready_i.
  - The payload is constant while redirect_v_o=1 and not accepted.
  - redirect_v_o deasserts the cycle after acceptance.
- A br_pkt_i.v arriving during e_wait_fe updates npc_r but not the held redirect payload. Those packets come from wrong-path instructions only if poisoned; poisoned instructions are not expected to produce br_pkt.v.
- reset_i mid-handshake drops redirect_v_o the next cycle with no acceptance.

## Structure
- bp_be_pkg holds:
  - bp_be_npc_check_state_e {e_run, e_wait_fe, e_resync}.
  - A bp_be_redirect_s typedef {pc, taken, metadata}.
- No sub-modules. The redirect holding register and saturating counter are inline. Use bsg_dff_reset_en for registers where convenient.

## Test plan
- Reset, then issue_pc 'h8000_0000 → poison_o=0, state e_run, counter 0.
- br_pkt {v,branch,btaken,npc='h8000_0100} with same-cycle issue_pc 'h8000_0100 → no poison. Next cycle npc_o='h8000_0100.
- Issue 'h8000_0004 while expecting 'h8000_0100 → poison_o=1. Next cycle redirect_v_o=1 with pc 'h8000_0100 and counter 1.
- Hold redirect_ready_i=0 for 5 cycles, issuing 3 instructions → all poisoned, payload stable, counter stays 1. Ready=1 → redirect_v_o=0 next cycle.
- In e_resync, issue 'h8000_0008 then 'h8000_0100 → first poisoned with no redirect, second passes, state e_run.
- npc_w_v_i='h8000_2000 during e_wait_fe → redirect_v_o=0 next cycle, issue 'h8000_2000 passes, counter unchanged.
- Force the counter to all-ones and cause a mispredict → count stays saturated.
